pht_gshare: RTL and testbench



---
 rtl/pht_gshare.sv | 98 +++++++++
 tb/tb_pht_gshare.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pht_gshare.sv
// Pattern history table of saturating counters with a speculative global history register.
// The table is indexed by PC bits, optionally XORed with history (gshare).
module pht_gshare #(
   parameter int INDEX_WIDTH = 8,
   parameter int CTR_WIDTH   = 2,
   parameter int GHR_WIDTH   = 8,
   parameter int GSHARE_EN   = 1,
   parameter int PC_WIDTH    = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [PC_WIDTH-1:0]  rd_pc_i,
   input  logic                 pred_en_i,
   output logic                 br_prediction_o,
   output logic                 br_confident_o,
   output logic [GHR_WIDTH-1:0] pred_ghr_o,
   input  logic                 update_en_i,
   input  logic [PC_WIDTH-1:0]  update_pc_i,
   input  logic [GHR_WIDTH-1:0] update_ghr_i,
   input  logic                 br_taken_i,
   input  logic                 mispredict_i
);

   localparam int DEPTH = 2**INDEX_WIDTH;
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = {1'b0, {(CTR_WIDTH-1){1'b1}}};
   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
   localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;

   logic [CTR_WIDTH-1:0]   table_q [DEPTH];
   logic [GHR_WIDTH-1:0]   ghr_q;
   logic [GHR_WIDTH-1:0]   ghr_d;
   logic [INDEX_WIDTH-1:0] rdIdx;
   logic [INDEX_WIDTH-1:0] updIdx;
   logic [CTR_WIDTH-1:0]   rdCtr;
   logic [CTR_WIDTH-1:0]   updCtr;
   logic [CTR_WIDTH-1:0]   updCtr_d;
   logic [GHR_WIDTH-1:0]   repairGhr;
   logic [GHR_WIDTH-1:0]   specGhr;
   logic                   unusedBits;

   // The update side hashes with the snapshot carried by the branch, never the live GHR.
   generate
      if (GSHARE_EN != 0) begin : g_gshare
         assign rdIdx  = rd_pc_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
         assign updIdx = update_pc_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(update_ghr_i);
      end else begin : g_bimodal
         assign rdIdx  = rd_pc_i[INDEX_WIDTH+1:2];
         assign updIdx = update_pc_i[INDEX_WIDTH+1:2];
      end
   endgenerate

   assign rdCtr           = table_q[rdIdx];
   assign updCtr          = table_q[updIdx];
   assign br_prediction_o = rdCtr[CTR_WIDTH-1];
   assign br_confident_o  = (rdCtr == CTR_MIN) || (rdCtr == CTR_MAX);
   assign pred_ghr_o      = ghr_q;

   always_comb begin
      updCtr_d = updCtr;
      if (br_taken_i) begin
         if (updCtr != CTR_MAX) updCtr_d = updCtr + CTR_WIDTH'(1);
      end else begin
         if (updCtr != CTR_MIN) updCtr_d = updCtr - CTR_WIDTH'(1);
      end
   end

   generate
      if (GHR_WIDTH == 1) begin : g_ghr1
         assign repairGhr = br_taken_i;
         assign specGhr   = br_prediction_o;
      end else begin : g_ghrN
         assign repairGhr = {update_ghr_i[GHR_WIDTH-2:0], br_taken_i};
         assign specGhr   = {ghr_q[GHR_WIDTH-2:0], br_prediction_o};
      end
   endgenerate

   // A repair discards any speculative shift in the same cycle: that fetch is on the flushed path.
   always_comb begin
      ghr_d = ghr_q;
      if (mispredict_i) ghr_d = repairGhr;
      else if (pred_en_i) ghr_d = specGhr;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_INIT;
         ghr_q <= '0;
      end else begin
         if (update_en_i) table_q[updIdx] <= updCtr_d;
         ghr_q <= ghr_d;
      end
   end

   assign unusedBits = ^{rd_pc_i[PC_WIDTH-1:INDEX_WIDTH+2], rd_pc_i[1:0],
                         update_pc_i[PC_WIDTH-1:INDEX_WIDTH+2], update_pc_i[1:0],
                         update_ghr_i, ghr_q};

endmodule

// File: tb/tb_pht_gshare.sv
// Self-checking bench for pht_gshare: randomized run of the default gshare configuration
// against a table/history model, plus directed runs of a small 3-bit bimodal configuration.
module tb_pht_gshare;

   logic        clk = 1'b0;
   logic        rst_i;

   logic [31:0] rdPc, updPc;
   logic        predEn, updEn, taken, mis;
   logic [7:0]  updGhr;
   logic        pred, conf;
   logic [7:0]  ghrOut;

   logic [31:0] sRdPc, sUpdPc;
   logic        sPredEn, sUpdEn, sTaken, sMis;
   logic [3:0]  sUpdGhr;
   logic        sPred, sConf;
   logic [3:0]  sGhr;

   int errors = 0;
   int checks = 0;
   int modelCtr [256];
   int modelGhr;

   always #5 clk = ~clk;

   pht_gshare u_dut (
      .clk_i(clk), .rst_i(rst_i),
      .rd_pc_i(rdPc), .pred_en_i(predEn),
      .br_prediction_o(pred), .br_confident_o(conf), .pred_ghr_o(ghrOut),
      .update_en_i(updEn), .update_pc_i(updPc), .update_ghr_i(updGhr),
      .br_taken_i(taken), .mispredict_i(mis)
   );

   pht_gshare #(.INDEX_WIDTH(4), .CTR_WIDTH(3), .GHR_WIDTH(4), .GSHARE_EN(0), .PC_WIDTH(32)) u_small (
      .clk_i(clk), .rst_i(rst_i),
      .rd_pc_i(sRdPc), .pred_en_i(sPredEn),
      .br_prediction_o(sPred), .br_confident_o(sConf), .pred_ghr_o(sGhr),
      .update_en_i(sUpdEn), .update_pc_i(sUpdPc), .update_ghr_i(sUpdGhr),
      .br_taken_i(sTaken), .mispredict_i(sMis)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic waitEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 256; i++) modelCtr[i] = 1;
      modelGhr = 0;
   endtask

   function automatic int modelIdx(input logic [31:0] pc, input int g);
      return int'(pc[9:2]) ^ g;
   endfunction

   task automatic idleMain();
      predEn = 1'b0; updEn = 1'b0; mis = 1'b0; taken = 1'b0;
      updPc = '0; updGhr = '0;
   endtask

   // Drives one cycle on the main DUT, checks outputs against the model, then advances the model.
   task automatic applyStimulus(input logic pe, input logic [31:0] rpc, input logic ue,
                                input logic [31:0] upc, input logic [7:0] ug,
                                input logic tk, input logic mp);
      int ri, ui, c, expPred, nextGhr;
      predEn = pe; rdPc = rpc; updEn = ue; updPc = upc; updGhr = ug; taken = tk; mis = mp;
      #4;
      ri = modelIdx(rpc, modelGhr);
      c = modelCtr[ri];
      expPred = (c >= 2) ? 1 : 0;
      checkOutput("pred", 32'(pred), 32'(expPred));
      checkOutput("conf", 32'(conf), (c == 0 || c == 3) ? 32'd1 : 32'd0);
      checkOutput("ghr", 32'(ghrOut), 32'(modelGhr));
      nextGhr = modelGhr;
      if (mp) nextGhr = ((int'(ug) << 1) | int'(tk)) & 255;
      else if (pe) nextGhr = ((modelGhr << 1) | expPred) & 255;
      if (ue) begin
         ui = modelIdx(upc, int'(ug));
         if (tk) modelCtr[ui] = (modelCtr[ui] < 3) ? modelCtr[ui] + 1 : 3;
         else    modelCtr[ui] = (modelCtr[ui] > 0) ? modelCtr[ui] - 1 : 0;
      end
      modelGhr = nextGhr;
      waitEdge();
   endtask

   function automatic logic [31:0] randPc();
      logic [31:0] p;
      p = $urandom;
      p[9:2] = 8'((($urandom_range(0, 7) * 37) ^ ($urandom_range(0, 1) ? modelGhr : 0)) & 255);
      return p;
   endfunction

   function automatic logic [7:0] randGhr();
      case ($urandom_range(0, 3))
         0: return 8'h00;
         1: return 8'(modelGhr);
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic randomCycles(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), randPc(), 1'($urandom_range(0, 9) < 6),
                       randPc(), randGhr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
      end
   endtask

   // Small-DUT check at the current sample point.
   task automatic checkSmallCtr(input string tag, input int expCtr);
      checkOutput({tag, "Pred"}, 32'(sPred), (expCtr >= 4) ? 32'd1 : 32'd0);
      checkOutput({tag, "Conf"}, 32'(sConf), (expCtr == 0 || expCtr == 7) ? 32'd1 : 32'd0);
   endtask

   initial begin
      int expCtr;
      rst_i = 1'b1;
      rdPc = '0;
      idleMain();
      sRdPc = '0; sPredEn = 1'b0; sUpdEn = 1'b0; sUpdPc = '0; sUpdGhr = '0; sTaken = 1'b0; sMis = 1'b0;
      modelReset();

      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         rdPc = 32'(i) << 2;
         #1;
         checkOutput("rstPred", 32'(pred), 32'd0);
         checkOutput("rstConf", 32'(conf), 32'd0);
         checkOutput("rstGhr", 32'(ghrOut), 32'd0);
      end
      checkOutput("rstSmallGhr", 32'(sGhr), 32'd0);
      checkSmallCtr("rstSmall", 3);

      @(negedge clk);
      rst_i = 1'b0;
      waitEdge();

      applyStimulus(1'b0, 32'h14, 1'b1, 32'h14, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h14, 1'b0, 32'h00, 8'h00, 1'b0, 1'b0);
      checkOutput("bypassNewPred", 32'(pred), 32'd1);

      randomCycles(3000);

      predEn = 1'b1; updEn = 1'b1; mis = 1'b1; taken = 1'b1; updGhr = 8'h5A;
      #1;
      rst_i = 1'b1;
      #1;
      checkOutput("midRstGhr", 32'(ghrOut), 32'd0);
      modelReset();
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         rdPc = 32'(i) << 2;
         #1;
         checkOutput("midRstPred", 32'(pred), 32'd0);
         checkOutput("midRstConf", 32'(conf), 32'd0);
      end
      checkOutput("midRstGhrHeld", 32'(ghrOut), 32'd0);
      @(negedge clk);
      idleMain();
      rst_i = 1'b0;
      waitEdge();
      applyStimulus(1'b0, 32'h1C, 1'b1, 32'h1C, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h1C, 1'b0, 32'h00, 8'h00, 1'b0, 1'b0);
      checkOutput("postRstUpdate", 32'(pred), 32'd1);
      randomCycles(500);
      idleMain();

      sRdPc = 32'h40; sUpdPc = 32'h40; sUpdEn = 1'b1; sTaken = 1'b1;
      expCtr = 3;
      for (int k = 0; k < 5; k++) begin
         #4;
         checkSmallCtr("satUp", expCtr);
         waitEdge();
         expCtr = (expCtr < 7) ? expCtr + 1 : 7;
      end
      sTaken = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #4;
         checkSmallCtr("satDown", expCtr);
         waitEdge();
         expCtr = (expCtr > 0) ? expCtr - 1 : 0;
      end
      sUpdEn = 1'b0;
      #4;
      checkSmallCtr("satFloor", 0);
      checkOutput("satFloorVal", 32'(expCtr), 32'd0);

      sUpdPc = 32'h44; sTaken = 1'b1; sUpdEn = 1'b1;
      repeat (4) waitEdge();
      sUpdEn = 1'b0; sRdPc = 32'h44;
      #4;
      checkSmallCtr("trained", 7);

      sMis = 1'b1; sUpdGhr = 4'b0101; sTaken = 1'b1;
      waitEdge(); #4;
      checkOutput("repair", 32'(sGhr), 32'b1011);
      sUpdGhr = 4'b0010; sPredEn = 1'b1;
      waitEdge(); #4;
      checkOutput("repairOverSpec", 32'(sGhr), 32'b0101);
      sUpdGhr = 4'b0101;
      waitEdge(); #4;
      checkOutput("repairOverSpec2", 32'(sGhr), 32'b1011);
      sMis = 1'b0;
      waitEdge(); #4;
      checkOutput("specShift1", 32'(sGhr), 32'b0111);
      waitEdge(); #4;
      checkOutput("specShift2", 32'(sGhr), 32'b1111);
      sRdPc = 32'h40;
      waitEdge(); #4;
      checkOutput("specShiftNT", 32'(sGhr), 32'b1110);
      sPredEn = 1'b0;
      waitEdge(); #4;
      checkOutput("ghrHold", 32'(sGhr), 32'b1110);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
